// File: rtl/alu_pkg.sv
// alu_pkg: op encodings and FSM state shared by the multicycle ALU
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_MUL, OP_MULH
  } op_t;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_multicycle_mul_iter.sv
// mul_iter: iterative shift-add unsigned multiplier, one partial product per cycle
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [WIDTH:0]     w_sum;
  // product is the accumulator after the iteration happening this cycle
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign product = {w_sum, r_acc[WIDTH-1:1]};
  assign busy    = r_busy;
  assign last    = r_busy && r_cnt == '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_acc  <= '0;
    end else if (start && !r_busy) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH - 1);
      r_a    <= a;
      r_acc  <= {{WIDTH{1'b0}}, b};
    end else if (r_busy) begin
      r_acc  <= product;
      r_cnt  <= r_cnt - CW'(1);
      r_busy <= r_cnt != '0;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: register-file ALU with single-cycle ops and iterative multiply
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [IDXW-1:0]  aindex,
  input  logic [IDXW-1:0]  bindex,
  input  logic [IDXW-1:0]  yindex,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_index,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDXW-1:0]  rdindex,
  output logic [WIDTH-1:0] rddata,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             negative
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0]   r_regs [NREGS];
  state_t             r_state;
  op_t                r_op;
  logic [IDXW-1:0]    r_y;
  logic               r_done, r_c, r_z, r_n;
  op_t                w_op;
  logic [WIDTH-1:0]   w_a, w_b, w_sres, w_mres, w_res;
  logic [WIDTH:0]     w_add, w_sub;
  logic [SW-1:0]      w_sh;
  logic [2*WIDTH-1:0] w_prod;
  logic [IDXW-1:0]    w_yi;
  logic               w_acc, w_is_mul, w_sc, w_mc, w_c, w_swe, w_mwe, w_we, w_mbusy, w_last;
  assign w_op     = op_t'(op);
  assign w_a      = r_regs[aindex];
  assign w_b      = r_regs[bindex];
  assign w_acc    = start && r_state == S_IDLE;
  assign w_is_mul = w_op == OP_MUL || w_op == OP_MULH;
  assign w_sh     = w_b[SW-1:0];
  assign w_add    = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub    = {1'b0, w_a} - {1'b0, w_b};
  always_comb begin
    w_sres = '0;
    w_sc   = 1'b0;
    case (w_op)
      OP_ADD: {w_sc, w_sres} = w_add;
      OP_SUB: {w_sc, w_sres} = w_sub;
      OP_AND: w_sres = w_a & w_b;
      OP_OR:  w_sres = w_a | w_b;
      OP_XOR: w_sres = w_a ^ w_b;
      OP_SHR: begin
        w_sres = w_a >> w_sh;
        w_sc   = w_sh != '0 && |(w_a & (WIDTH'(1) << (w_sh - SW'(1))));
      end
      default: ;
    endcase
  end
  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .CLK    (CLK),
    .RST    (RST),
    .start  (w_acc && w_is_mul),
    .a      (w_a),
    .b      (w_b),
    .busy   (w_mbusy),
    .product(w_prod),
    .last   (w_last)
  );
  assign w_mres = r_op == OP_MULH ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
  assign w_mc   = r_op == OP_MUL && |w_prod[2*WIDTH-1:WIDTH];
  assign w_mwe  = r_state == S_MUL && w_last;
  assign w_swe  = w_acc && !w_is_mul;
  assign w_we   = w_swe || w_mwe;
  assign w_res  = w_mwe ? w_mres : w_sres;
  assign w_c    = w_mwe ? w_mc : w_sc;
  assign w_yi   = w_mwe ? r_y : yindex;
  // the external load is assigned last so it wins a same-index collision
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_done <= w_we;
      if (w_we) begin
        r_c <= w_c;
        r_z <= w_res == '0;
        r_n <= w_res[WIDTH-1];
        r_regs[w_yi] <= w_res;
      end
      if (w_acc && w_is_mul) begin
        r_state <= S_MUL;
        r_op    <= w_op;
        r_y     <= yindex;
      end else if (w_mwe) begin
        r_state <= S_IDLE;
      end
      if (wr_en) r_regs[wr_index] <= wr_data;
    end
  end
  assign rddata   = r_regs[rdindex];
  assign busy     = w_mbusy;
  assign done     = r_done;
  assign carry    = r_c;
  assign zero     = r_z;
  assign negative = r_n;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table vectors, multicycle corner cases and random ops vs a reference model
module tb_alu_multicycle;
  logic        CLK = 0, RST = 1, start = 0, wr_en = 0;
  logic [2:0]  op = 0, aindex = 0, bindex = 0, yindex = 0, wr_index = 0, rdindex = 0;
  logic [15:0] wr_data = 0, rddata;
  logic        busy, done, carry, zero, negative;
  int tests = 0, fails = 0;
  logic [15:0] mreg [8];

  alu_multicycle #(.WIDTH(16), .NREGS(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .aindex(aindex), .bindex(bindex),
    .yindex(yindex), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .rdindex(rdindex), .rddata(rddata), .busy(busy), .done(done),
    .carry(carry), .zero(zero), .negative(negative)
  );

  always #5 CLK = ~CLK;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  o;
    logic [15:0] a, b, r;
    logic        c, z, n;
  } vec_t;
  vec_t tbl [13];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [15:0] a, b,
                                output logic [15:0] r, output logic c);
    int unsigned s, p;
    int amt;
    s = {16'd0, a} + {16'd0, b};
    p = {16'd0, a} * {16'd0, b};
    amt = int'(b) % 16;
    r = 0;
    c = 0;
    case (o)
      0: begin r = s[15:0]; c = s > 32'hFFFF; end
      1: begin r = a - b; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a >> amt; c = amt == 0 ? 1'b0 : ((a >> (amt - 1)) & 16'd1) != 0; end
      6: begin r = p[15:0]; c = p[31:16] != 0; end
      default: begin r = p[31:16]; c = 0; end
    endcase
  endfunction

  task automatic load(input int idx, input logic [15:0] d);
    wr_en = 1; wr_index = 3'(idx); wr_data = d;
    tick;
    wr_en = 0;
    mreg[idx] = d;
  endtask

  task automatic do_op(input logic [2:0] o, input int ai, input int bi, input int yi,
                       output logic [15:0] gr, output logic gc, output logic gz, output logic gn);
    logic [15:0] er;
    logic ec, bh;
    int n;
    model(o, mreg[ai], mreg[bi], er, ec);
    op = o; aindex = 3'(ai); bindex = 3'(bi); yindex = 3'(yi); start = 1;
    tick;
    start = 0;
    if (o >= 6) begin
      bh = busy;
      n = 0;
      while (!done && n < 40) begin
        tick;
        n++;
        if (!done) bh &= busy;
      end
      chk("mul_latency", n, 16);
      chk("mul_busy_held", bh, 1);
    end else begin
      chk("done_pulse", done, 1);
    end
    chk("busy_after", busy, 0);
    mreg[yi] = er;
    rdindex = 3'(yi);
    #1;
    gr = rddata; gc = carry; gz = zero; gn = negative;
    chk("result", rddata, er);
    chk("carry", carry, ec);
    chk("zero", zero, er == 0);
    chk("negative", negative, er[15]);
    tick;
    chk("done_clear", done, 0);
  endtask

  initial begin
    logic [15:0] gr;
    logic gc, gz, gn, early;
    int n;
    tbl[0]  = '{3'd0, 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{3'd1, 16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{3'd6, 16'h1234, 16'h0100, 16'h3400, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{3'd7, 16'h1234, 16'h0100, 16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'd5, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{3'd5, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd4, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    tick; tick;
    RST = 0;
    for (int i = 0; i < 8; i++) begin
      rdindex = 3'(i);
      #1;
      chk("reset_reg", rddata, 0);
    end
    chk("reset_flags", {carry, zero, negative}, 0);
    chk("reset_busy_done", {busy, done}, 0);

    for (int i = 0; i < 13; i++) begin
      load(1, tbl[i].a);
      load(2, tbl[i].b);
      do_op(tbl[i].o, 1, 2, 3 + i % 5, gr, gc, gz, gn);
      chk($sformatf("vec%0d_r", i), gr, tbl[i].r);
      chk($sformatf("vec%0d_flags", i), {gc, gz, gn}, {tbl[i].c, tbl[i].z, tbl[i].n});
    end

    load(1, 16'h1234);
    load(2, 16'h0100);
    op = 6; aindex = 1; bindex = 2; yindex = 5; start = 1;
    tick;
    start = 0;
    n = 0;
    repeat (3) begin tick; n++; end
    op = 0; aindex = 2; yindex = 3; start = 1;
    tick;
    n++;
    start = 0;
    early = done;
    while (!done && n < 40) begin tick; n++; end
    chk("ignore_latency", n, 16);
    chk("ignore_no_done", early, 0);
    mreg[5] = 16'h3400;
    rdindex = 5; #1;
    chk("ignore_r5", rddata, 16'h3400);
    chk("ignore_flags", {carry, zero, negative}, 3'b100);
    rdindex = 3; #1;
    chk("ignore_r3", rddata, mreg[3]);
    tick;
    chk("ignore_done_clear", done, 0);

    op = 6; aindex = 1; bindex = 2; yindex = 5; start = 1;
    tick;
    start = 0;
    repeat (4) tick;
    chk("abort_busy_before", busy, 1);
    RST = 1;
    tick;
    RST = 0;
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_flags", {carry, zero, negative}, 0);
    rdindex = 5; #1;
    chk("abort_r5", rddata, 0);
    repeat (20) tick;
    chk("abort_stays_idle", {busy, done}, 0);
    rdindex = 5; #1;
    chk("abort_no_late_write", rddata, 0);

    load(1, 16'h0003);
    load(2, 16'h0005);
    op = 0; aindex = 1; bindex = 2; yindex = 3; start = 1;
    wr_en = 1; wr_index = 3; wr_data = 16'hBEEF;
    tick;
    start = 0; wr_en = 0;
    mreg[3] = 16'hBEEF;
    chk("collide_done", done, 1);
    rdindex = 3; #1;
    chk("collide_r3", rddata, 16'hBEEF);
    chk("collide_flags", {carry, zero, negative}, 0);
    tick;
    chk("collide_done_clear", done, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0)
        load($urandom_range(0, 7), 16'($urandom));
      else
        do_op(3'($urandom_range(0, 7)), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), gr, gc, gz, gn);
    end
    for (int i = 0; i < 8; i++) begin
      rdindex = 3'(i);
      #1;
      chk($sformatf("final_r%0d", i), rddata, mreg[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised second-generation ALU with an integrated register file. It supports add/sub, logic, shift, and unsigned multiply (low/high half), and exposes registered carry/zero/negative flags. Multiplies run on an iterative shift-add datapath under a start/busy/done handshake. An external load port and a debug read port connect it to the console's instruction sequencer.

## Interface
Parameters:
- `WIDTH`, default 16: datapath and register width. Power of two, ≥ 4.
- `NREGS`, default 8: register count. Power of two, ≥ 2. Derived `IDXW = $clog2(NREGS)`.

Ports:
- `CLK` in, 1: single clock; all state changes on its rising edge.
- `RST` in, 1: synchronous, active-high reset.
- `start` in, 1: request an operation; sampled only in IDLE.
- `op` in, 3: operation code (encodings in package).
- `aindex`, `bindex`, `yindex` in, IDXW: source A, source B, destination.
- `wr_en` in, 1: external load strobe.
- `wr_index` in, IDXW: external load destination.
- `wr_data` in, WIDTH: external load data.
- `rdindex` in, IDXW: debug read select.
- `rddata` out, WIDTH: combinational `reg[rdindex]`.
- `busy` out, 1: multiply in progress.
- `done` out, 1: one-cycle pulse after a result write.
- `carry`, `zero`, `negative` out, 1 each: flags.

## Operation
- Ops:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR.
  - 5 SHR: logical right shift of A by `B[$clog2(WIDTH)-1:0]`.
  - 6 MUL: low WIDTH bits of A×B.
  - 7 MULH: high WIDTH bits of A×B, unsigned.
- Accept: `start`=1 while in IDLE. Operands are read combinationally at the accept edge; `op` and `yindex` are latched. Later input changes have no effect.
- `start` while `busy`=1 is ignored. There is no queue.
- FSM states: IDLE, MUL.
  - IDLE→MUL on accepted op 6/7.
  - MUL→IDLE on the final iteration edge.
  - Ops 0–5 never leave IDLE.
- Multiplier: WIDTH iterations, one per cycle, with a 2·WIDTH product accumulator and a down-counter from WIDTH−1 to 0.
- Flags update only on ALU writes; loads never change them.
  - carry:
    - ADD: carry-out.
    - SUB: borrow (1 iff A<B unsigned).
    - MUL: 1 iff high half ≠ 0.
    - MULH: 0. Logic ops: 0.
    - SHR: last bit shifted out; 0 when the shift amount is 0.
  - zero: written result == 0.
  - negative: written result[WIDTH−1].
- Load port: when `wr_en`=1, `reg[wr_index] <= wr_data` at the edge, in any state.
  - Same-edge collision with an ALU write to the same index: the load wins.
  - The ALU `done` and flags still update.
- `yindex` may equal `aindex` or `bindex`. Operands are captured before the write.

## Timing
- Reset values: all registers 0; carry, zero, negative, busy, done all 0; FSM in IDLE.
- Single-cycle ops:
  - Accepted at edge k, result and flags written at edge k.
  - `done`=1 for the cycle after edge k. `busy` stays 0.
  - A new `start` is accepted at edge k+1.
- MUL/MULH:
  - Accepted at edge k; `busy`=1 from edge k until edge k+WIDTH.
  - Result and flags written at edge k+WIDTH.
  - `busy`=0 and `done`=1 for the cycle after edge k+WIDTH.
  - Next accept is possible at edge k+WIDTH+1.
- `done` is a pulse: it deasserts after one cycle unless another write occurs.
- `RST` during MUL: abort at that edge with no destination write and no flag change. `busy`=0, `done`=0, IDLE from the next cycle.
- `RST` has priority over `start` and `wr_en` on the same edge.
- `rddata` reflects a write starting in the cycle after its edge. There is no bypass.

## Structure
- Package `alu_pkg`: op encodings (`OP_ADD` … `OP_MULH`) as a 3-bit typedef, and the FSM state typedef.
- Sub-module `mul_iter`, parametrised by WIDTH:
  - Inputs: `CLK`, `RST`, `start`, A, B.
  - Outputs: busy, a 2·WIDTH product, and a last-iteration strobe.
- Top level holds the register file, operand muxes, combinational single-cycle datapath, flag logic and write arbitration.

## Test plan
(All scenarios use WIDTH=16, NREGS=8.)
- Load r1=0x0003, r2=0x0005; ADD a=1 b=2 y=3.
  - r3=0x0008, carry=0 zero=0 negative=0.
  - `done` high exactly one cycle after the accept; `busy` never high.
- SUB a=1 b=2 y=4 → r4=0xFFFE, carry=1, negative=1. Then SUB a=1 b=1 y=4 → r4=0, zero=1.
- Load r1=0x1234, r2=0x0100.
  - MUL y=5 → r5=0x3400, carry=1, `busy` high 16 cycles, `done` after edge k+16.
  - MULH y=6 → r6=0x0012, carry=0.
  - `start` with op ADD pulsed mid-multiply → ignored; no extra `done`.
- Load r1=0x8001, r2=0x0001; SHR y=7 → r7=0x4000, carry=1. With r2=0, r7=0x8001 and carry=0.
- Start MUL with y=5 and assert `RST` at iteration 5: busy=0, done=0, r5=0, flags=0 next cycle.
- ADD y=3 with `wr_en`=1, `wr_index`=3, `wr_data`=0xBEEF on the accept edge → r3=0xBEEF, flags from the ADD, `done` pulses.
